// File: rtl/sseg_scan_rx.sv
// rtl/sseg_scan_rx.sv - scanned seven-segment receiver: decodes three digits into a 0-999 frame value.
// Define SSEG_RX_CHANGE_ONLY_EN to suppress valid when a frame repeats the held value/blank.
module sseg_scan_rx #(
  parameter int STABLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] SSeg,
  input  logic [3:0] an,
  output logic [9:0] value,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic [2:0] blank,
  output logic       valid,
  output logic       err
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 2);

  typedef enum logic [1:0] {S_COLLECT, S_CONV, S_OUT} state_t;

  state_t        state;
  logic [3:0]    an_q, an_p;
  logic [6:0]    seg_q, seg_p;
  logic [CW-1:0] cnt;
  logic [2:0]    mask;
  logic [3:0]    d2, d1, d0;
  logic [2:0]    db;
  logic [3:0]    w2, w1, w0;
  logic [2:0]    wb;
  logic [9:0]    acc;
  logic [1:0]    step;

  logic [1:0] slot;
  logic       an_ok;
  logic       same;
  logic       fire;
  logic [3:0] dig;
  logic       dblank;
  logic       legal;
  logic [2:0] cap_mask;
  logic [3:0] n2, n1, n0;
  logic [2:0] nb;
  logic [3:0] cur;

  // slot 3 is the sign position: counted for stability but never captured
  always_comb begin
    an_ok = 1'b1;
    slot  = 2'd3;
    case (an_q)
      4'b1110: slot = 2'd0;
      4'b0111: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b1101: slot = 2'd3;
      default: an_ok = 1'b0;
    endcase
  end

  always_comb begin
    dig    = 4'd0;
    dblank = 1'b0;
    legal  = 1'b1;
    case (seg_q)
      7'h40: dig = 4'd0;
      7'h79: dig = 4'd1;
      7'h24: dig = 4'd2;
      7'h30: dig = 4'd3;
      7'h19: dig = 4'd4;
      7'h12: dig = 4'd5;
      7'h02: dig = 4'd6;
      7'h78: dig = 4'd7;
      7'h00: dig = 4'd8;
      7'h10: dig = 4'd9;
      7'h7F: dblank = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign same = an_ok && ({an_q, seg_q} == {an_p, seg_p});
  assign fire = same && (cnt == CNT_PRE);

  // slot contents with the digit being captured this cycle merged in
  always_comb begin
    n2 = d2;
    n1 = d1;
    n0 = d0;
    nb = db;
    cap_mask = mask;
    case (slot)
      2'd0: begin n0 = dig; nb[0] = dblank; cap_mask[0] = 1'b1; end
      2'd1: begin n1 = dig; nb[1] = dblank; cap_mask[1] = 1'b1; end
      2'd2: begin n2 = dig; nb[2] = dblank; cap_mask[2] = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (step)
      2'd0:    cur = w2;
      2'd1:    cur = w1;
      default: cur = w0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_COLLECT;
      an_q  <= 4'hF;
      an_p  <= 4'hF;
      seg_q <= 7'h7F;
      seg_p <= 7'h7F;
      cnt   <= '0;
      mask  <= 3'b000;
      d2    <= 4'd0;
      d1    <= 4'd0;
      d0    <= 4'd0;
      db    <= 3'b000;
      w2    <= 4'd0;
      w1    <= 4'd0;
      w0    <= 4'd0;
      wb    <= 3'b000;
      acc   <= 10'd0;
      step  <= 2'd0;
      value <= 10'd0;
      bcd2  <= 4'd0;
      bcd1  <= 4'd0;
      bcd0  <= 4'd0;
      blank <= 3'b000;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      an_q  <= an;
      seg_q <= SSeg;
      an_p  <= an_q;
      seg_p <= seg_q;
      valid <= 1'b0;
      err   <= 1'b0;

      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      case (state)
        S_COLLECT: begin
          if (fire && slot != 2'd3) begin
            if (!legal) begin
              err  <= 1'b1;
              mask <= 3'b000;
            end else begin
              d2 <= n2;
              d1 <= n1;
              d0 <= n0;
              db <= nb;
              if (cap_mask == 3'b111) begin
                state <= S_CONV;
                mask  <= 3'b000;
                w2    <= n2;
                w1    <= n1;
                w0    <= n0;
                wb    <= nb;
                acc   <= 10'd0;
                step  <= 2'd0;
              end else begin
                mask <= cap_mask;
              end
            end
          end
        end
        S_CONV: begin
          acc  <= (acc << 3) + (acc << 1) + {6'd0, cur};
          step <= step + 2'd1;
          if (step == 2'd2)
            state <= S_OUT;
        end
        S_OUT: begin
          value <= acc;
          bcd2  <= w2;
          bcd1  <= w1;
          bcd0  <= w0;
          blank <= wb;
`ifdef SSEG_RX_CHANGE_ONLY_EN
          valid <= (acc != value) || (wb != blank);
`else
          valid <= 1'b1;
`endif
          state <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan_rx.sv
// tb/tb_sseg_scan_rx.sv - directed-vector bench for sseg_scan_rx.
module tb_sseg_scan_rx;

  localparam logic [3:0] AN_U = 4'b1110;
  localparam logic [3:0] AN_T = 4'b0111;
  localparam logic [3:0] AN_H = 4'b1011;
  localparam logic [3:0] AN_S = 4'b1101;
  localparam logic [3:0] AN_X = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] SSeg = 7'h7F;
  logic [3:0] an = AN_X;
  logic [9:0] value;
  logic [3:0] bcd2, bcd1, bcd0;
  logic [2:0] blank;
  logic       valid;
  logic       err;

  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int vcyc = 0;
  int nvec = 0;
  int nbad = 0;

  sseg_scan_rx #(.STABLE_CYC(16)) dut (
    .clk(clk), .rst(rst), .SSeg(SSeg), .an(an),
    .value(value), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .blank(blank), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      nvalid <= nvalid + 1;
      vcyc   <= cyc;
    end
    if (err) nerr <= nerr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    SSeg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int v, input int h, input int t, input int u, input int b);
    chk({tag, "_value"}, 32'(value), 32'(v));
    chk({tag, "_bcd2"}, 32'(bcd2), 32'(h));
    chk({tag, "_bcd1"}, 32'(bcd1), 32'(t));
    chk({tag, "_bcd0"}, 32'(bcd0), 32'(u));
    chk({tag, "_blank"}, 32'(blank), 32'(b));
  endtask

  initial begin
    int nv0;
    int ne0;
    int hs;

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
    rst = 1'b0;
    show(AN_X, 7'h7F, 5);

    // basic frame 247, latency from hundreds capture
    nv0 = nvalid;
    show(AN_U, 7'h78, 40);
    show(AN_T, 7'h19, 40);
    hs = cyc;
    show(AN_H, 7'h24, 40);
    show(AN_S, 7'h7F, 40);
    show(AN_X, 7'h7F, 5);
    chk("basic_nvalid", 32'(nvalid - nv0), 1);
    chk("basic_latency", 32'(vcyc), 32'(hs + 21));
    check_outs("basic", 247, 2, 4, 7, 0);

    // reset while converting a frame
    nv0 = nvalid;
    show(AN_U, 7'h79, 40);
    show(AN_T, 7'h79, 40);
    show(AN_H, 7'h79, 18);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("midrst", 0, 0, 0, 0, 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_err", 32'(err), 0);
    rst = 1'b0;
    show(AN_X, 7'h7F, 15);
    chk("midrst_novalid", 32'(nvalid - nv0), 0);

    // short tens glitch must not capture
    nv0 = nvalid;
    show(AN_U, 7'h30, 40);
    show(AN_T, 7'h02, 10);
    show(AN_U, 7'h30, 20);
    show(AN_H, 7'h00, 40);
    show(AN_X, 7'h7F, 5);
    chk("glitch_novalid", 32'(nvalid - nv0), 0);
    show(AN_T, 7'h02, 40);
    show(AN_X, 7'h7F, 5);
    chk("glitch_nvalid", 32'(nvalid - nv0), 1);
    chk("glitch_value", 32'(value), 863);

    // illegal tens pattern aborts the frame
    nv0 = nvalid;
    ne0 = nerr;
    show(AN_U, 7'h79, 40);
    show(AN_T, 7'h55, 40);
    show(AN_H, 7'h10, 40);
    show(AN_T, 7'h10, 40);
    show(AN_X, 7'h7F, 5);
    chk("illegal_nerr", 32'(nerr - ne0), 1);
    chk("illegal_novalid", 32'(nvalid - nv0), 0);
    show(AN_U, 7'h10, 40);
    show(AN_X, 7'h7F, 5);
    chk("illegal_nvalid", 32'(nvalid - nv0), 1);
    chk("illegal_value", 32'(value), 999);

    // blank hundreds, invalid anode burst
    nv0 = nvalid;
    show(AN_H, 7'h7F, 40);
    show(AN_T, 7'h40, 40);
    show(4'b1100, 7'h12, 30);
    chk("burst_novalid", 32'(nvalid - nv0), 0);
    show(AN_U, 7'h12, 40);
    show(AN_X, 7'h7F, 5);
    chk("blank_nvalid", 32'(nvalid - nv0), 1);
    check_outs("blank", 5, 0, 0, 5, 3'b100);

    // repeated frames; illegal sign pattern is ignored
    nv0 = nvalid;
    ne0 = nerr;
    for (int f = 0; f < 3; f++) begin
      show(AN_U, (f == 2) ? 7'h19 : 7'h30, 40);
      show(AN_T, 7'h24, 40);
      show(AN_H, 7'h79, 40);
      show(AN_S, 7'h55, 40);
      show(AN_X, 7'h7F, 5);
    end
`ifdef SSEG_RX_CHANGE_ONLY_EN
    chk("repeat_nvalid", 32'(nvalid - nv0), 2);
`else
    chk("repeat_nvalid", 32'(nvalid - nv0), 3);
`endif
    chk("repeat_value", 32'(value), 124);
    chk("sign_noerr", 32'(nerr - ne0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
